// File: rtl/dual_issue_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dual_issue_scheduler_if                                                  |
// | Decode-pair to issue-stage bundle for the dual-issue scheduler.          |
// |   master : decode side - drives slot fields and flush, sees issue result |
// |   slave  : scheduler   - consumes slot fields, drives issue/fwd/stall    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface dual_issue_scheduler_if #(
   parameter int RS    = 5,
   parameter int FWD_W = 3
);
   logic             s0_valid,   s1_valid;
   logic [RS-1:0]    s0_rs1,     s0_rs2,     s0_rd;
   logic [RS-1:0]    s1_rs1,     s1_rs2,     s1_rd;
   logic             s0_use_rs1, s0_use_rs2, s1_use_rs1, s1_use_rs2;
   logic             s0_rf_wen,  s1_rf_wen;
   logic             s0_mem_op,  s1_mem_op;
   logic             s0_load,    s1_load;
   logic             s0_ctrl,    s1_ctrl;
   logic             flush;

   logic             dec_ready;
   logic             br_issue_valid,  br_issue_sel;
   logic             mem_issue_valid, mem_issue_sel;
   logic [FWD_W-1:0] fwd_br_rs1,  fwd_br_rs2;
   logic [FWD_W-1:0] fwd_mem_rs1, fwd_mem_rs2;
   logic             stall;

   modport master (
      output s0_valid, s0_rs1, s0_rs2, s0_rd, s0_use_rs1, s0_use_rs2,
             s0_rf_wen, s0_mem_op, s0_load, s0_ctrl,
             s1_valid, s1_rs1, s1_rs2, s1_rd, s1_use_rs1, s1_use_rs2,
             s1_rf_wen, s1_mem_op, s1_load, s1_ctrl, flush,
      input  dec_ready, br_issue_valid, br_issue_sel, mem_issue_valid, mem_issue_sel,
             fwd_br_rs1, fwd_br_rs2, fwd_mem_rs1, fwd_mem_rs2, stall
   );

   modport slave (
      input  s0_valid, s0_rs1, s0_rs2, s0_rd, s0_use_rs1, s0_use_rs2,
             s0_rf_wen, s0_mem_op, s0_load, s0_ctrl,
             s1_valid, s1_rs1, s1_rs2, s1_rd, s1_use_rs1, s1_use_rs2,
             s1_rf_wen, s1_mem_op, s1_load, s1_ctrl, flush,
      output dec_ready, br_issue_valid, br_issue_sel, mem_issue_valid, mem_issue_sel,
             fwd_br_rs1, fwd_br_rs2, fwd_mem_rs1, fwd_mem_rs2, stall
   );
endinterface
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dual_issue_scheduler                                                     |
// | Issue-stage controller for the two-wide core. Steers the decoded pair    |
// | (slot0 older, slot1 younger) onto the Branch and Memory pipes, splits    |
// | pairs on structural/RAW/WAW conflicts, inserts one bubble on load-use,   |
// | tracks EX/MEM/WB destinations per pipe and drives the forwarding selects.|
// | Ports: clk, rst (sync, active-high), bus (slave modport): slot fields    |
// |        and flush in; dec_ready, issue valid/sel per pipe, four fwd       |
// |        selects and stall out.                                            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dual_issue_scheduler #(
   parameter int RS    = 5,
   parameter int FWD_W = 3
) (
   input  wire logic             clk,
   input  wire logic             rst,
   dual_issue_scheduler_if.slave bus
);
   localparam logic [0:0] c_NORMAL = 1'b0;
   localparam logic [0:0] c_HOLD1  = 1'b1;
   localparam int         c_BR     = 0;
   localparam int         c_MEM    = 1;
   localparam int         c_EX     = 0;

   logic [0:0]              r_state, w_state_nxt;
   // Tracking indexed [pipe][stage]; stage 0 = EX, 1 = MEM, 2 = WB.
   logic [1:0][2:0]         r_trk_valid, r_trk_wen, r_trk_load;
   logic [1:0][2:0][RS-1:0] r_trk_rd;

   logic          w_lu0, w_lu1, w_raw, w_waw, w_pair;
   logic          w_br_valid, w_br_sel, w_mem_valid, w_mem_sel, w_dec_ready, w_stall;
   logic [RS-1:0] w_br_rs1, w_br_rs2, w_br_rd, w_mem_rs1, w_mem_rs2, w_mem_rd;
   logic          w_br_use1, w_br_use2, w_br_wen, w_br_load;
   logic          w_mem_use1, w_mem_use2, w_mem_wen, w_mem_load;

   // A load sitting in Memory EX cannot forward yet: any reader must wait a cycle.
   function automatic logic f_load_use(input logic use_a, input logic [RS-1:0] src_a,
                                       input logic use_b, input logic [RS-1:0] src_b);
      logic hit_a, hit_b;
      hit_a = use_a && (src_a != '0) && (src_a == r_trk_rd[c_MEM][c_EX]);
      hit_b = use_b && (src_b != '0) && (src_b == r_trk_rd[c_MEM][c_EX]);
      return r_trk_valid[c_MEM][c_EX] && r_trk_load[c_MEM][c_EX] && (hit_a || hit_b);
   endfunction

   // Scanned youngest-last so the youngest stage (and Branch within a stage) wins.
   // Code = 2*stage + pipe + 1 gives Branch_EX=1 ... Memory_WB=6.
   function automatic logic [FWD_W-1:0] f_fwd(input logic use_src, input logic [RS-1:0] src);
      logic [FWD_W-1:0] sel;
      sel = '0;
      if (use_src && (src != '0)) begin
         for (int st = 2; st >= 0; st--) begin
            for (int p = 1; p >= 0; p--) begin
               if (r_trk_valid[p][st] && r_trk_wen[p][st] && (r_trk_rd[p][st] == src))
                  sel = FWD_W'(2 * st + p + 1);
            end
         end
      end
      return sel;
   endfunction

   assign w_lu0 = bus.s0_valid && f_load_use(bus.s0_use_rs1, bus.s0_rs1, bus.s0_use_rs2, bus.s0_rs2);
   assign w_lu1 = bus.s1_valid && f_load_use(bus.s1_use_rs1, bus.s1_rs1, bus.s1_use_rs2, bus.s1_rs2);
   assign w_raw = bus.s0_rf_wen && (bus.s0_rd != '0) &&
                  ((bus.s1_use_rs1 && (bus.s1_rs1 == bus.s0_rd)) ||
                   (bus.s1_use_rs2 && (bus.s1_rs2 == bus.s0_rd)));
   assign w_waw = bus.s0_rf_wen && bus.s1_rf_wen && (bus.s0_rd != '0) && (bus.s0_rd == bus.s1_rd);
   assign w_pair = bus.s0_valid && bus.s1_valid && !(bus.s0_mem_op && bus.s1_mem_op) &&
                   !(bus.s0_ctrl && bus.s1_ctrl) && !bus.s0_ctrl && !w_raw && !w_waw &&
                   !w_lu0 && !w_lu1;

   always_comb begin
      w_br_valid  = 1'b0;
      w_br_sel    = 1'b0;
      w_mem_valid = 1'b0;
      w_mem_sel   = 1'b0;
      w_dec_ready = 1'b0;
      w_stall     = 1'b0;
      w_state_nxt = r_state;
      if (rst) begin
         w_state_nxt = c_NORMAL;
      end else if (bus.flush) begin
         // Decode regs are flushed upstream, so the pair counts as consumed.
         w_dec_ready = 1'b1;
         w_state_nxt = c_NORMAL;
      end else if (r_state == c_HOLD1 || (!bus.s0_valid && bus.s1_valid)) begin
         if (!bus.s1_valid) begin
            w_dec_ready = 1'b1;
            w_state_nxt = c_NORMAL;
         end else if (w_lu1) begin
            w_stall = 1'b1;
         end else begin
            w_mem_valid = bus.s1_mem_op;
            w_br_valid  = !bus.s1_mem_op;
            w_mem_sel   = 1'b1;
            w_br_sel    = 1'b1;
            w_dec_ready = 1'b1;
            w_state_nxt = c_NORMAL;
         end
      end else if (bus.s0_valid) begin
         if (w_lu0) begin
            w_stall = 1'b1;
         end else if (w_pair) begin
            w_br_valid  = 1'b1;
            w_mem_valid = 1'b1;
            // s0 takes Memory when it is the memory op or when s1 needs the Branch pipe.
            w_mem_sel   = !(bus.s0_mem_op || bus.s1_ctrl);
            w_br_sel    = bus.s0_mem_op || bus.s1_ctrl;
            w_dec_ready = 1'b1;
         end else begin
            w_mem_valid = bus.s0_mem_op;
            w_br_valid  = !bus.s0_mem_op;
            w_dec_ready = !bus.s1_valid;
            w_state_nxt = bus.s1_valid ? c_HOLD1 : c_NORMAL;
         end
      end
   end

   always_comb begin
      w_br_rs1   = w_br_sel  ? bus.s1_rs1     : bus.s0_rs1;
      w_br_rs2   = w_br_sel  ? bus.s1_rs2     : bus.s0_rs2;
      w_br_rd    = w_br_sel  ? bus.s1_rd      : bus.s0_rd;
      w_br_use1  = w_br_sel  ? bus.s1_use_rs1 : bus.s0_use_rs1;
      w_br_use2  = w_br_sel  ? bus.s1_use_rs2 : bus.s0_use_rs2;
      w_br_wen   = w_br_sel  ? bus.s1_rf_wen  : bus.s0_rf_wen;
      w_br_load  = w_br_sel  ? bus.s1_load    : bus.s0_load;
      w_mem_rs1  = w_mem_sel ? bus.s1_rs1     : bus.s0_rs1;
      w_mem_rs2  = w_mem_sel ? bus.s1_rs2     : bus.s0_rs2;
      w_mem_rd   = w_mem_sel ? bus.s1_rd      : bus.s0_rd;
      w_mem_use1 = w_mem_sel ? bus.s1_use_rs1 : bus.s0_use_rs1;
      w_mem_use2 = w_mem_sel ? bus.s1_use_rs2 : bus.s0_use_rs2;
      w_mem_wen  = w_mem_sel ? bus.s1_rf_wen  : bus.s0_rf_wen;
      w_mem_load = w_mem_sel ? bus.s1_load    : bus.s0_load;
   end

   assign bus.dec_ready       = w_dec_ready;
   assign bus.br_issue_valid  = w_br_valid;
   assign bus.br_issue_sel    = w_br_valid && w_br_sel;
   assign bus.mem_issue_valid = w_mem_valid;
   assign bus.mem_issue_sel   = w_mem_valid && w_mem_sel;
   assign bus.stall           = w_stall;
   assign bus.fwd_br_rs1      = w_br_valid  ? f_fwd(w_br_use1,  w_br_rs1)  : '0;
   assign bus.fwd_br_rs2      = w_br_valid  ? f_fwd(w_br_use2,  w_br_rs2)  : '0;
   assign bus.fwd_mem_rs1     = w_mem_valid ? f_fwd(w_mem_use1, w_mem_rs1) : '0;
   assign bus.fwd_mem_rs2     = w_mem_valid ? f_fwd(w_mem_use2, w_mem_rs2) : '0;

   // Entries shift EX->MEM->WB every cycle; EX refills from this cycle's issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_NORMAL;
         r_trk_valid <= '0;
         r_trk_wen   <= '0;
         r_trk_load  <= '0;
         r_trk_rd    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_trk_valid <= {r_trk_valid[1][1:0], w_mem_valid, r_trk_valid[0][1:0], w_br_valid};
         r_trk_wen   <= {r_trk_wen[1][1:0],   w_mem_wen,   r_trk_wen[0][1:0],   w_br_wen};
         r_trk_load  <= {r_trk_load[1][1:0],  w_mem_load,  r_trk_load[0][1:0],  w_br_load};
         r_trk_rd    <= {r_trk_rd[1][1:0],    w_mem_rd,    r_trk_rd[0][1:0],    w_br_rd};
      end
   end
endmodule
`default_nettype wire
